// File: rtl/binary_sum_splitter.sv
// Splits one WIDTH-bit total into five shares (A..E) that sum back exactly and differ by at most one.
// A restoring divide-by-5 retires one quotient bit per clock; the result is held in DONE until out_ready.
module binary_sum_splitter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] total,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] total_q;
  logic [WIDTH-1:0] q_q;
  logic [2:0]       r_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q, e_q;

  logic [3:0]       rs_d;
  logic             ge_d;
  logic [2:0]       r_d;
  logic [WIDTH-1:0] q_d;

  // One restoring step; the remainder stays in 0..4, so wrapping 3-bit subtraction is exact.
  always_comb begin
    rs_d       = {r_q, total_q[cnt_q]};
    ge_d       = (rs_d >= 4'd5);
    r_d        = ge_d ? (rs_d[2:0] - 3'd5) : rs_d[2:0];
    q_d        = q_q;
    q_d[cnt_q] = ge_d;
  end

  function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] base, input logic inc);
    return base + {{(WIDTH-1){1'b0}}, inc};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      total_q     <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      e_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            total_q <= total;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= CW'(WIDTH - 1);
            state_q <= DIV;
          end
        end
        DIV: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            // Remainder r spreads as +1 onto the first r shares, keeping A >= B >= C >= D >= E.
            a_q         <= bump(q_d, r_d > 3'd0);
            b_q         <= bump(q_d, r_d > 3'd1);
            c_q         <= bump(q_d, r_d > 3'd2);
            d_q         <= bump(q_d, r_d > 3'd3);
            e_q         <= q_d;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign C         = c_q;
  assign D         = d_q;
  assign E         = e_q;

  logic [WIDTH+2:0] share_sum;
  assign share_sum = {3'b000, a_q} + {3'b000, b_q} + {3'b000, c_q} + {3'b000, d_q} + {3'b000, e_q};

  a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));
  a_sum_exact:  assert property (@(posedge clk) disable iff (rst)
                                 out_valid |-> (share_sum == {3'b000, total_q}));

endmodule

// File: tb/tb_binary_sum_splitter.sv
module tb_binary_sum_splitter;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] total;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] A, B, C, D, E;

  int n_tests = 0;
  int n_fail  = 0;

  binary_sum_splitter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .total(total),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .C(C), .D(D), .E(E)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Five-operand adder tree as a plain behavioural sum.
  function automatic int tree(input int a, input int b, input int c, input int d, input int e);
    return a + b + c + d + e;
  endfunction

  task automatic check_shares(input string tag, input int x);
    int q, r;
    q = x / 5;
    r = x % 5;
    check({tag, "_A"}, A, q + ((r > 0) ? 1 : 0));
    check({tag, "_B"}, B, q + ((r > 1) ? 1 : 0));
    check({tag, "_C"}, C, q + ((r > 2) ? 1 : 0));
    check({tag, "_D"}, D, q + ((r > 3) ? 1 : 0));
    check({tag, "_E"}, E, q);
    check({tag, "_tree"}, tree(A, B, C, D, E), x);
  endtask

  // Accept x, measure latency to out_valid, check shares; optionally complete the output handshake.
  task automatic split(input int x, input bit release_out, input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    total    = x[WIDTH-1:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= WIDTH + 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, lat, WIDTH);
    check_shares(tag, x);
    if (release_out) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_drop_valid"}, out_valid, 0);
      check({tag, "_back_idle"}, in_ready, 1);
    end
  endtask

  initial begin
    time t_acc[3];
    int  b2b_tot[3];
    int  x;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; total = '0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_A", A, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    split(0, 1, "zero");
    split(7, 1, "seven");
    split(4, 1, "four");
    split(65535, 1, "full");
    split(65534, 1, "full_m1");

    // Backpressure: hold result while in_valid pulses with a new total.
    split(23, 0, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      total    = 16'd99;
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_A", A, 5);
      check("bp_hold_C", C, 5);
      check("bp_hold_D", D, 4);
      check("bp_hold_E", E, 4);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);

    // Asynchronous reset eight cycles into a divide.
    @(negedge clk);
    in_valid = 1'b1;
    total    = 16'd1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_A", A, 0);
    check("mid_rst_B", B, 0);
    check("mid_rst_D", D, 0);
    check("mid_rst_E", E, 0);
    @(negedge clk);
    rst = 1'b0;
    split(1000, 1, "after_rst");

    // Back-to-back with both handshakes held high.
    b2b_tot = '{10, 11, 12};
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    total     = 16'd10;
    for (int k = 0; k < 3; k++) begin
      t_acc[k] = 0;
      for (int i = 0; i < 3 * WIDTH; i++) begin
        if (in_ready) break;
        @(negedge clk);
      end
      check("b2b_ready_seen", in_ready, 1);
      @(posedge clk);
      t_acc[k] = $time;
      #1;
      if (k < 2) total = b2b_tot[k+1][WIDTH-1:0];
      for (int i = 0; i < WIDTH + 4; i++) begin
        @(posedge clk); #1;
        if (out_valid) break;
      end
      check("b2b_out_valid", out_valid, 1);
      check_shares("b2b", b2b_tot[k]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_gap01", 32'((t_acc[1] - t_acc[0]) / 10), WIDTH + 2);
    check("b2b_gap12", 32'((t_acc[2] - t_acc[1]) / 10), WIDTH + 2);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Random round trip through the adder tree.
    for (int n = 0; n < 1000; n++) begin
      x = int'($urandom_range(0, (1 << WIDTH) - 1));
      split(x, 1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/binary_sum_splitter.md
Name: binary_sum_splitter

Overview:
- Inverse of the pipelined five-operand adder tree: accepts one WIDTH-bit total and splits it into five shares A..E.
- Shares satisfy A+B+C+D+E == total exactly, with max share minus min share <= 1.
- Uses a sequential restoring divide-by-5: one quotient bit per clock, with valid/ready handshakes on both sides.
- Sits upstream of the adder tree in test and balancing paths, so that tree(split(x)) == x.

Parameters:
- WIDTH, 16, width of the total and of each share; must be >= 3.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  total is valid this cycle.
- in_ready  output  1  block can accept a total.
- total  input  WIDTH  value to split; sampled on the in_valid && in_ready edge.
- out_valid  output  1  shares A..E are valid.
- out_ready  input  1  downstream accepts the shares.
- A, B, C, D, E  output  WIDTH each  registered shares.

Behaviour:
- Reset:
  - rst asserted at any time (including mid-divide or mid-DONE): state=IDLE; out_valid=0; A..E=0; internal dividend, quotient, remainder and bit counter = 0.
  - in_ready = (state==IDLE) && !rst, so it is 0 while rst is high.
- State IDLE:
  - in_ready=1.
  - On the edge where in_valid && in_ready: latch total, clear quotient and remainder, set count=WIDTH-1, go to DIV.
  - in_valid without acceptance has no effect.
- State DIV:
  - in_ready=0, out_valid=0.
  - Each edge performs one restoring step, MSB first:
    - r' = {r, total[count]}, where r is 3 bits wide.
    - If r' >= 5: r = r'-5 and q[count]=1; else r = r' and q[count]=0.
    - count decrements.
  - On the step where count==0, the same edge:
    - registers A = q+(r>0), B = q+(r>1), C = q+(r>2), D = q+(r>3), E = q, using the final q and r of that step;
    - sets out_valid=1 and goes to DONE.
- Latency: out_valid rises exactly WIDTH rising edges after the accept edge (16 cycles at default).
- State DONE:
  - out_valid=1; A..E held stable; in_ready=0.
  - On the edge where out_valid && out_ready: out_valid=0, go to IDLE. A..E keep their last values but are don't-care while out_valid=0.
  - in_valid is ignored in DONE (no bypass).
  - Minimum spacing between accepts is WIDTH+2 cycles.
- Width and arithmetic rules:
  - q <= floor((2^WIDTH-1)/5), so q+1 never overflows WIDTH bits.
  - Remainder is always in 0..4.
  - Shares are ordered A >= B >= C >= D >= E.
- Invariants (checked by assertion): in_ready && out_valid never both 1; sum of shares == latched total whenever out_valid=1.
- No combinational path from in_valid or out_ready to any output other than via state.

Test Plan:
- Zero and small totals:
  - total=0 -> after 16 cycles, A..E=0, out_valid=1.
  - total=7 -> A=2, B=2, C=1, D=1, E=1.
  - total=4 -> A=B=C=D=1, E=0.
- Full-scale totals:
  - total=16'hFFFF (65535) -> A..E all 13107.
  - total=65534 -> A=B=C=D=13107, E=13106.
  - Sum of shares == total in each case.
- Backpressure: accept total=23, then hold out_ready=0 for 10 cycles while pulsing in_valid with total=99.
  - A..E stay 5,5,5,4,4 and out_valid stays 1.
  - in_ready stays 0 and 99 is not accepted.
  - Raise out_ready -> out_valid drops next edge and in_ready=1.
- Reset mid-operation:
  - Assert rst asynchronously 8 cycles into DIV on total=1000 -> out_valid=0 and A..E=0 immediately; in_ready=0 while rst is high.
  - Release rst, then send 1000 -> A..E all 200 after 16 cycles.
- Back-to-back throughput: in_valid and out_ready held high with totals 10, 11, 12 -> accepts 18 cycles apart.
  - Outputs: 2,2,2,2,2; then 3,2,2,2,2; then 3,3,2,2,2.
- Round trip: 1000 random totals, each split and its shares fed to the five-operand adder tree -> tree output == original total for every sample.
